fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Sequences the instruction memory.
- Owns the word-indexed program counter and presents it to imem every cycle.
- Applies branch/jump redirects by driving imem's flush inputs, and holds/replays fetches under decode stall.
- Tags the 1-cycle-latency imem output with fetch_valid/fetch_pc for decode; also supports halt/resume from execute.

Parameters:
- RESET_PC, 0: pc value after reset (word index).
- PC_STEP, 1: sequential increment (imem is word-addressed).
- PC_WIDTH, 32: pc width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- stall  input  1  decode cannot accept current fetch_pc/instruction
- redirect_valid  input  1  execute resolves taken branch or jump this cycle
- redirect_is_jump  input  1  1=jump, 0=branch; qualified by redirect_valid
- redirect_target  input  PC_WIDTH  new pc
- halt_req  input  1  stop fetching
- resume  input  1  leave HALT
- pc  output  PC_WIDTH  address to imem
- imem_branch  output  1  to imem branch input (flush)
- imem_jump  output  1  to imem jump input (flush)
- fetch_valid  output  1  imem instruction this cycle is valid
- fetch_pc  output  PC_WIDTH  pc of the instruction imem outputs this cycle
- halted  output  1  in HALT state

Behaviour:
- Reset (rst=0, async): state=BOOT, pc_q=RESET_PC, fetch_pc=RESET_PC, fetch_valid=0, halted=0. Perf counters are 0.
- imem_branch and imem_jump are combinational outputs; all others are registered except the pc mux.
- States:
  - BOOT: 1 cycle. pc=RESET_PC. pc_q<=RESET_PC+PC_STEP, fetch_pc<=RESET_PC, fetch_valid<=1. Stall is ignored. Next state RUN. A redirect or halt_req in BOOT is handled as in RUN.
  - RUN, no event: pc=pc_q. pc_q<=pc_q+PC_STEP (modulo 2^PC_WIDTH, wraps silently). fetch_pc<=pc, fetch_valid<=1.
  - RUN, stall && fetch_valid: pc=fetch_pc (combinational replay so imem re-outputs the same instruction). pc_q, fetch_pc and fetch_valid hold.
  - RUN, stall && !fetch_valid: stall has no effect; a bubble needs no holding.
  - RUN, redirect_valid: priority over stall.
    - Same cycle: imem_jump=redirect_is_jump, imem_branch=!redirect_is_jump, so imem outputs 0 next cycle.
    - pc_q<=redirect_target, fetch_valid<=0.
    - Next cycle: pc=redirect_target. Target instruction arrives 2 cycles after redirect, giving exactly 1 bubble.
  - RUN, halt_req: next state HALT, fetch_valid<=0. pc_q keeps the value it would have had (redirect applied first if simultaneous).
  - HALT:
    - imem_jump=1 continuously, so imem outputs 0; fetch_valid=0, halted=1, pc=pc_q frozen.
    - A redirect in HALT updates pc_q only.
    - resume && !halt_req → RUN; the first fetch is pc_q, valid 1 cycle later.
    - resume && halt_req together → stay in HALT.
- Back-to-back redirects: each applies; only the last target is fetched.
- Reset asserted mid-operation returns to BOOT immediately regardless of state.

Optional Feature:
- FETCH_PERF_CNT_EN defined: adds output ports perf_fetched[31:0], perf_bubbles[31:0], perf_redirects[31:0]. All are saturating at 2^32-1 and cleared by reset.
  - perf_fetched counts cycles with fetch_valid && !stall.
  - perf_bubbles counts cycles with !fetch_valid outside HALT.
  - perf_redirects counts cycles with redirect_valid.
- Not defined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package h2bp: fetch_state_t enum {BOOT, RUN, HALT} and the RESET_PC default constant.
- One sub-module, fetch_perf_cnt (saturating 32-bit counter bank), instantiated only under FETCH_PERF_CNT_EN.

Test Plan:
- Release reset, no stimulus → pc 0,1,2,3 on successive cycles; fetch_valid 0 then 1; fetch_pc 0,1,2 lagging pc by one.
- At fetch_pc=2, stall for 3 cycles → pc=2 during stall, fetch_pc stays 2, fetch_valid=1. After release, fetch_pc=3 next cycle.
- Redirect branch target 9 while pc=4 → imem_branch=1 that cycle; next cycle pc=9, fetch_valid=0; following cycle fetch_pc=9, valid=1.
- Redirect jump target 0 and stall asserted same cycle → imem_jump=1, stall ignored, pc=0 next cycle.
- halt_req at pc=6, redirect to 3 while halted, then resume → halted=1 and imem_jump=1 throughout; after resume pc=3, fetch_pc=3 valid one cycle later.
- With FETCH_PERF_CNT_EN: run the redirect case → perf_redirects=1, perf_bubbles=2 (BOOT + redirect), perf_fetched equals count of valid unstalled cycles.

Source files
------------

// File: rtl/h2bp_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package h2bp;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'd0;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Bank of saturating 32-bit event counters for fetch_ctrl.
// Only built when FETCH_PERF_CNT_EN is defined.
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_cnt #(
    parameter int unsigned N_CNT = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N_CNT-1:0]        inc_i,
    output logic [N_CNT-1:0][31:0]  cnt_o
);

    logic [N_CNT-1:0][31:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CNT; i++) begin
                if (inc_i[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + 32'd1;
                end
            end
        end
    end

    assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the pc, drives imem flushes, replays under stall, halts/resumes.
// Optional perf counters (perf_fetched/bubbles/redirects) under FETCH_PERF_CNT_EN.
module fetch_ctrl
    import h2bp::*;
#(
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = PC_WIDTH'(RESET_PC_DEFAULT),
    parameter logic [PC_WIDTH-1:0]  PC_STEP  = PC_WIDTH'(1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic                redirect_is_jump,
    input  logic [PC_WIDTH-1:0] redirect_target,
    input  logic                halt_req,
    input  logic                resume,
    output logic [PC_WIDTH-1:0] pc,
    output logic                imem_branch,
    output logic                imem_jump,
    output logic                fetch_valid,
    output logic [PC_WIDTH-1:0] fetch_pc,
    output logic                halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_bubbles,
    output logic [31:0]         perf_redirects
`endif
);

    fetch_state_t          state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_q_d;
    logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic                  fetch_valid_q, fetch_valid_d;
    logic                  replay;

    // Redirect outranks stall, so a stalled fetch is only replayed when no redirect is pending.
    assign replay = (state_q == RUN) && stall && fetch_valid_q && !redirect_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT, RUN: state_d = halt_req ? HALT : RUN;
            HALT:      if (resume && !halt_req) state_d = RUN;
            default:   state_d = BOOT;
        endcase
    end

    always_comb begin
        pc          = pc_q;
        imem_branch = 1'b0;
        imem_jump   = 1'b0;
        unique case (state_q)
            BOOT, RUN: begin
                if (state_q == BOOT) begin
                    pc = RESET_PC;
                end else if (replay) begin
                    pc = fetch_pc_q;
                end
                imem_jump   = redirect_valid && redirect_is_jump;
                imem_branch = redirect_valid && !redirect_is_jump;
            end
            HALT: begin
                imem_jump = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        pc_q_d        = pc_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_valid_d = fetch_valid_q;
        if (state_q == HALT) begin
            fetch_valid_d = 1'b0;
            if (redirect_valid) begin
                pc_q_d = redirect_target;
            end
        end else begin
            if (redirect_valid) begin
                pc_q_d        = redirect_target;
                fetch_pc_d    = pc;
                fetch_valid_d = 1'b0;
            end else if (!replay) begin
                pc_q_d        = pc + PC_STEP;
                fetch_pc_d    = pc;
                fetch_valid_d = 1'b1;
            end
            if (halt_req) begin
                fetch_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            fetch_pc_q    <= RESET_PC;
            fetch_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_q_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = fetch_pc_q;
    assign halted      = (state_q == HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [2:0]       perf_inc;
    logic [2:0][31:0] perf_cnt;

    assign perf_inc = {redirect_valid,
                       !fetch_valid_q && (state_q != HALT),
                       fetch_valid_q && !stall};

    fetch_perf_cnt #(
        .N_CNT(3)
    ) u_perf (
        .clk_i (clk),
        .rst_ni(rst),
        .inc_i (perf_inc),
        .cnt_o (perf_cnt)
    );

    assign perf_fetched   = perf_cnt[0];
    assign perf_bubbles   = perf_cnt[1];
    assign perf_redirects = perf_cnt[2];
`endif

endmodule
